// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: queues operand pairs and sweeps opcodes 0..7 per pair into the ALU (optional pause via ALU_SEQ_PAUSE_EN)
module alu_operand_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
`ifdef ALU_SEQ_PAUSE_EN
    input  logic                                 pause,
`endif
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [DATA_WIDTH-1:0]                in_portA,
    input  logic [DATA_WIDTH-1:0]                in_portB,
    output logic [2:0]                           opcode_out,
    output logic [DATA_WIDTH-1:0]                portA_out,
    output logic [DATA_WIDTH-1:0]                portB_out,
    output logic                                 op_valid,
    output logic                                 sweep_done,
    output logic                                 busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] mem_a [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_b [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [HW-1:0]         hold, hold_nxt;
    logic [2:0]            opcode_nxt;
    logic [DATA_WIDTH-1:0] a_nxt, b_nxt;
    logic                  push, pop, paused, last;

`ifdef ALU_SEQ_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    assign in_ready   = fifo_count != CW'(FIFO_DEPTH);
    assign push       = in_valid && in_ready;
    assign last       = state == SWEEP && opcode_out == 3'd7 && hold == HOLD_LAST;
    assign pop        = fifo_count != '0 && (state == IDLE || (last && !paused));
    assign busy       = state == SWEEP;
    assign op_valid   = busy && !paused;
    assign sweep_done = last && !paused;

    // next sweep position: a pop restarts at opcode 0, otherwise step the hold counter and opcode unless paused
    always_comb begin
        state_nxt  = state;
        hold_nxt   = hold;
        opcode_nxt = opcode_out;
        a_nxt      = portA_out;
        b_nxt      = portB_out;
        if (pop) begin
            state_nxt  = SWEEP;
            hold_nxt   = '0;
            opcode_nxt = 3'd0;
            a_nxt      = mem_a[rd_ptr];
            b_nxt      = mem_b[rd_ptr];
        end else if (state == SWEEP && !paused) begin
            hold_nxt   = hold == HOLD_LAST ? '0 : hold + HW'(1);
            opcode_nxt = hold == HOLD_LAST ? opcode_out + 3'd1 : opcode_out;
            state_nxt  = last ? IDLE : SWEEP;
        end
    end

    // state, presentation registers and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold       <= '0;
            opcode_out <= '0;
            portA_out  <= '0;
            portB_out  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state      <= state_nxt;
            hold       <= hold_nxt;
            opcode_out <= opcode_nxt;
            portA_out  <= a_nxt;
            portB_out  <= b_nxt;
            wr_ptr     <= wr_ptr + PW'(push);
            rd_ptr     <= rd_ptr + PW'(pop);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage; stale entries are unreachable once the pointers are cleared
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_portA;
            mem_b[wr_ptr] <= in_portB;
        end
    end
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: checks two sequencer instances (hold 1 and hold 4) against a queue-based sweep model
module tb_alu_operand_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic pause_s = 1'b0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [1:0] r, v, sd, bz;
    logic [1:0][2:0] opc, cnt;
    logic [1:0][7:0] pa, pb;
    logic [25:0] obs [2];
    int checks = 0;
    int failures = 0;

    int hd[2], tl[2], pos[2];
    bit act[2];
    logic [7:0] ma[2][64], mb[2][64], ca[2], cb[2];

    always #5 clk = ~clk;

    alu_operand_sequencer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .HOLD_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef ALU_SEQ_PAUSE_EN
        .pause(pause_s),
`endif
        .in_valid(in_valid), .in_ready(r[0]), .in_portA(in_a), .in_portB(in_b),
        .opcode_out(opc[0]), .portA_out(pa[0]), .portB_out(pb[0]), .op_valid(v[0]),
        .sweep_done(sd[0]), .busy(bz[0]), .fifo_count(cnt[0])
    );

    alu_operand_sequencer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .HOLD_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
`ifdef ALU_SEQ_PAUSE_EN
        .pause(pause_s),
`endif
        .in_valid(in_valid), .in_ready(r[1]), .in_portA(in_a), .in_portB(in_b),
        .opcode_out(opc[1]), .portA_out(pa[1]), .portB_out(pb[1]), .op_valid(v[1]),
        .sweep_done(sd[1]), .busy(bz[1]), .fifo_count(cnt[1])
    );

    always_comb for (int d = 0; d < 2; d++) obs[d] = {opc[d], pa[d], pb[d], v[d], sd[d], bz[d], cnt[d], r[d]};

    function automatic int hc(int d);
        return d == 0 ? 1 : 4;
    endfunction

    function automatic logic [25:0] exp_vec(int d);
        int c;
        logic [2:0] o;
        c = tl[d] - hd[d];
        o = act[d] ? 3'(pos[d] / hc(d)) : 3'd0;
        return {o, ca[d], cb[d], act[d] && !pause_s, act[d] && !pause_s && pos[d] == 8 * hc(d) - 1,
                act[d], 3'(c), c != 4};
    endfunction

    task automatic model_step(int d);
        int c;
        bit pu, po, endp;
        if (!rst_n) begin
            hd[d] = 0; tl[d] = 0; act[d] = 0; pos[d] = 0; ca[d] = '0; cb[d] = '0;
            return;
        end
        c = tl[d] - hd[d];
        endp = act[d] && pos[d] == 8 * hc(d) - 1;
        pu = in_valid && c != 4;
        po = c != 0 && (!act[d] || (endp && !pause_s));
        if (act[d] && !pause_s) begin
            if (endp) begin act[d] = 0; pos[d] = 0; end
            else pos[d]++;
        end
        if (po) begin
            ca[d] = ma[d][hd[d] % 64]; cb[d] = mb[d][hd[d] % 64];
            hd[d]++; act[d] = 1; pos[d] = 0;
        end
        if (pu) begin
            ma[d][tl[d] % 64] = in_a; mb[d][tl[d] % 64] = in_b;
            tl[d]++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== 26'h1) begin
                failures++;
                $display("FAIL reset_values dut%0d got=%h exp=%h", d, obs[d], 26'h1);
            end
            checks++;
            if (obs[d] !== exp_vec(d)) begin
                failures++;
                $display("FAIL reset_model dut%0d got=%h exp=%h", d, obs[d], exp_vec(d));
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_sweep();
        int vc[2], dc[2];
        vc = '{0, 0}; dc = '{0, 0};
        in_valid = 1'b1; in_a = 8'd12; in_b = 8'd16;
        for (int i = 0; i < 40; i++) begin
            tick();
            in_valid = 1'b0;
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL single_sweep dut%0d cyc=%0d got=%h exp=%h", d, i, obs[d], exp_vec(d));
                end
                vc[d] += int'(v[d]);
                dc[d] += int'(sd[d]);
                if (sd[d]) begin
                    checks++;
                    if (opc[d] !== 3'd7 || pa[d] !== 8'd12 || pb[d] !== 8'd16) begin
                        failures++;
                        $display("FAIL single_done_op dut%0d got=%0d/%0d/%0d exp=7/12/16", d, opc[d], pa[d], pb[d]);
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (vc[d] != 8 * hc(d) || dc[d] != 1 || bz[d] !== 1'b0) begin
                failures++;
                $display("FAIL single_len dut%0d got valid=%0d done=%0d busy=%b exp valid=%0d done=1 busy=0",
                         d, vc[d], dc[d], bz[d], 8 * hc(d));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ta [2];
        logic [7:0] tb [2];
        int first, lastv, vc, d1, d2;
        ta = '{8'd32, 8'h81}; tb = '{8'hCF, 8'hB6};
        first = -1; lastv = -1; vc = 0; d1 = -1; d2 = -1;
        for (int i = 0; i < 80; i++) begin
            in_valid = i < 2;
            in_a = ta[i % 2]; in_b = tb[i % 2];
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL back_to_back dut%0d cyc=%0d got=%h exp=%h", d, i, obs[d], exp_vec(d));
                end
            end
            if (v[0]) begin
                vc++;
                if (first < 0) first = i;
                lastv = i;
            end
            if (sd[0]) begin
                if (d1 < 0) d1 = i; else d2 = i;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (vc != 16 || lastv - first != 15 || d2 - d1 != 8) begin
            failures++;
            $display("FAIL b2b_frame got valid=%0d span=%0d gap=%0d exp valid=16 span=15 gap=8",
                     vc, lastv - first, d2 - d1);
        end
    endtask

    task automatic test_backpressure();
        int mx;
        bit saw_full, saw_release;
        logic [2:0] prev;
        mx = 0; saw_full = 0; saw_release = 0; prev = '0;
        for (int i = 0; i < 200; i++) begin
            in_valid = i < 30;
            in_a = 8'($urandom); in_b = 8'($urandom);
            prev = cnt[0];
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL backpressure dut%0d cyc=%0d got=%h exp=%h", d, i, obs[d], exp_vec(d));
                end
            end
            if (int'(cnt[0]) > mx) mx = int'(cnt[0]);
            if (r[0] === 1'b0) saw_full = 1;
            if (prev == 3'd4 && cnt[0] != 3'd4 && !saw_release) begin
                saw_release = 1;
                checks++;
                if (cnt[0] !== 3'd3 || r[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL full_pop got cnt=%0d ready=%b exp cnt=3 ready=1", cnt[0], r[0]);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (mx != 4 || !saw_full || !saw_release) begin
            failures++;
            $display("FAIL fill_level got max=%0d full=%0d release=%0d exp max=4 full=1 release=1", mx, saw_full, saw_release);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            in_valid = i < 600 && $urandom_range(0, 3) == 0;
            in_a = 8'($urandom); in_b = 8'($urandom);
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", d, i, obs[d], exp_vec(d));
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        int dc;
        found = 0; dc = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            in_valid = i < 3;
            in_a = 8'($urandom); in_b = 8'($urandom);
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL reset_mid_pre dut%0d cyc=%0d got=%h exp=%h", d, i, obs[d], exp_vec(d));
                end
            end
            if (opc[0] == 3'd3 && v[0]) found = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (!found || cnt[0] !== 3'd2) begin
            failures++;
            $display("FAIL reset_mid_setup got found=%0d cnt=%0d exp found=1 cnt=2", found, cnt[0]);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs[d] !== 26'h1) begin
                failures++;
                $display("FAIL reset_mid_values dut%0d got=%h exp=%h", d, obs[d], 26'h1);
            end
        end
        for (int i = 0; i < 60; i++) begin
            tick();
            dc += int'(sd[0]) + int'(sd[1]);
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL reset_mid_post dut%0d cyc=%0d got=%h exp=%h", d, i, obs[d], exp_vec(d));
                end
            end
        end
        checks++;
        if (dc != 0) begin
            failures++;
            $display("FAIL reset_mid_done got pulses=%0d exp 0", dc);
        end
    endtask

`ifdef ALU_SEQ_PAUSE_EN
    task automatic test_pause();
        bit found;
        int n;
        found = 0; n = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            in_valid = i == 0;
            in_a = 8'($urandom); in_b = 8'($urandom);
            tick();
            if (opc[0] == 3'd5 && v[0]) found = 1;
        end
        in_valid = 1'b0;
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL pause_setup got found=0 exp found=1");
        end
        pause_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n++;
            checks++;
            if (v[0] !== 1'b0 || opc[0] !== 3'd5 || sd[0] !== 1'b0) begin
                failures++;
                $display("FAIL pause_hold got valid=%b op=%0d done=%b exp valid=0 op=5 done=0", v[0], opc[0], sd[0]);
            end
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL pause_model dut%0d got=%h exp=%h", d, obs[d], exp_vec(d));
                end
            end
        end
        pause_s = 1'b0;
        #0;
        checks++;
        if (v[0] !== 1'b1 || opc[0] !== 3'd5) begin
            failures++;
            $display("FAIL pause_resume got valid=%b op=%0d exp valid=1 op=5", v[0], opc[0]);
        end
        while (!sd[0] && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL pause_delay got=%0d exp=5", n);
        end
        for (int i = 0; i < 60; i++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs[d] !== exp_vec(d)) begin
                    failures++;
                    $display("FAIL pause_post dut%0d cyc=%0d got=%h exp=%h", d, i, obs[d], exp_vec(d));
                end
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_sweep();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef ALU_SEQ_PAUSE_EN
        test_pause();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
